ccff_chain_loader: RTL and testbench



---
 rtl/ccff_chain_loader.sv | 156 +++++++++++++++
 tb/tb_ccff_chain_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serializes valid/ready bitstream words onto one CLB configuration chain.
// Optional macro CCFF_VERIFY_EN adds a parity-checked recirculation pass after loading.
`default_nettype none

module ccff_chain_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              config_enable,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int HW = $clog2(WORD_W + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
`ifdef CCFF_VERIFY_EN
  localparam logic [1:0] S_VERIFY = 2'd2;
`endif
  localparam logic [CNT_W-1:0] CHAIN_CNT = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] WORD_CNT  = CNT_W'(WORD_W);

  logic [1:0]        state;
  logic [WORD_W-1:0] word_reg;
  logic [HW-1:0]     held;
  logic [CNT_W-1:0]  bits_left;

  logic              in_load;
  logic              shift;
  logic              take;
  logic              last_shift;
  logic [CNT_W-1:0]  left_after;
  logic [HW-1:0]     held_after;

  assign in_load    = (state == S_LOAD);
  assign shift      = in_load && (held != '0) && !abort;
  assign left_after = bits_left - CNT_W'(shift);
  assign held_after = held - HW'(shift);
  // A new word is requested only while the chain still needs bits beyond those held.
  assign cfg_ready  = in_load && !abort && (held_after == '0) && (bits_left > CNT_W'(held));
  assign take       = cfg_valid && cfg_ready;
  assign last_shift = shift && (left_after == '0);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      state     <= S_IDLE;
      word_reg  <= '0;
      held      <= '0;
      bits_left <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state     <= S_LOAD;
            bits_left <= CHAIN_CNT;
            held      <= '0;
          end
        end
        S_LOAD: begin
          if (abort) begin
            state <= S_IDLE;
            held  <= '0;
          end else begin
            bits_left <= left_after;
            if (take) begin
              // The final word keeps only the bits the chain still needs.
              word_reg <= cfg_data;
              held     <= (left_after >= WORD_CNT) ? HW'(WORD_W) : HW'(left_after);
            end else if (shift) begin
              word_reg <= word_reg >> 1;
              held     <= held_after;
            end
            if (last_shift) begin
`ifdef CCFF_VERIFY_EN
              state     <= S_VERIFY;
              bits_left <= CHAIN_CNT;
`else
              state     <= S_IDLE;
              done      <= 1'b1;
`endif
            end
          end
        end
`ifdef CCFF_VERIFY_EN
        S_VERIFY: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            bits_left <= bits_left - CNT_W'(1);
            if (bits_left == CNT_W'(1)) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CCFF_VERIFY_EN
  logic in_verify;
  logic verify_end;
  logic par_load;
  logic par_tail;
  logic err_flag;

  assign in_verify     = (state == S_VERIFY);
  assign verify_end    = in_verify && !abort && (bits_left == CNT_W'(1));
  // Recirculation feeds the tail back to the head, restoring the chain after CHAIN_LEN shifts.
  assign config_enable = shift || (in_verify && !abort);
  assign ccff_head     = in_load ? ((held != '0) && word_reg[0]) : (in_verify && ccff_tail);
  assign err           = err_flag;

  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      par_load <= 1'b0;
      par_tail <= 1'b0;
      err_flag <= 1'b0;
    end else if ((state == S_IDLE) && start && !abort) begin
      par_load <= 1'b0;
      par_tail <= 1'b0;
      err_flag <= 1'b0;
    end else begin
      if (shift) par_load <= par_load ^ word_reg[0];
      if (in_verify && !abort) par_tail <= par_tail ^ ccff_tail;
      if (verify_end) err_flag <= par_load ^ par_tail ^ ccff_tail;
    end
  end
`else
  logic unused_tail;

  assign unused_tail   = ccff_tail;
  assign config_enable = shift;
  assign ccff_head     = (held != '0) && word_reg[0] && in_load;
  assign err           = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: per-cycle vector table plus multi-cycle sequences.
`default_nettype none

module tb_ccff_chain_loader;

  localparam logic [19:0] EXP_CHAIN = 20'hA53CE;
  localparam logic [19:0] FLIP_MASK = 20'h00020;
`ifdef CCFF_VERIFY_EN
  localparam int EN_PER_LOAD = 40;
`else
  localparam int EN_PER_LOAD = 20;
`endif

  logic clk, rst_n, start, abort, valid, ready, head, en, tail, busy, done, err;
  logic [7:0]  data;
  logic [19:0] chain;
  logic        flip_arm;
  int          shift_cnt;

  int tests, fails;
  int n_en, n_done, n_late, n_bad, n_stall_en, n_gap;
  logic err_at_done;
  logic [7:0] words [3];

  typedef struct {
    logic st;
    logic ab;
    logic vl;
    logic [7:0] d;
    logic [4:0] exp;  // {ready, en, head, busy, done}
  } vec_t;
  vec_t vecs [24];
  int   n_vec;

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8), .CNT_W(16)) dut (
    .prog_clk(clk), .pReset_n(rst_n), .start(start), .abort(abort),
    .cfg_data(data), .cfg_valid(valid), .cfg_ready(ready),
    .ccff_head(head), .config_enable(en), .ccff_tail(tail),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chain model: 20-flop shift register; optional single-bit upset on the 20th shift.
  assign tail = chain[19];
  initial begin
    chain = '0;
    shift_cnt = 0;
  end
  always @(posedge clk) begin
    if (start && !busy) shift_cnt <= 0;
    else if (en) shift_cnt <= shift_cnt + 1;
    if (en)
      chain <= {chain[18:0], head} ^ ((flip_arm && shift_cnt == 19) ? FLIP_MASK : 20'h0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic vl, input logic [7:0] d, input logic [4:0] exp);
    vecs[n_vec] = '{st, 1'b0, vl, d, exp};
    n_vec++;
  endtask

  task automatic run_load(input int stall, input int abort_at);
    int idx;
    int gap;
    bit fin;
    logic gap_cyc;
    idx = 0; gap = 0; fin = 0;
    n_en = 0; n_done = 0; n_late = 0; n_bad = 0; n_stall_en = 0; err_at_done = 1'b0;
    @(negedge clk); start = 1'b1; valid = 1'b0; abort = 1'b0;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 120 && !fin; cyc++) begin
      gap_cyc = (idx == 1) && (stall != 0) && (n_en == 7 || (n_en >= 8 && gap < stall));
      valid = (idx < 3) && !gap_cyc;
      data  = (idx < 3) ? words[idx] : 8'h00;
      abort = (abort_at != 0) && (n_en == abort_at);
      #1;
      if (abort) begin
        @(negedge clk); abort = 1'b0; valid = 1'b0; #1;
        chk("abort_idle", {29'd0, busy, en, ready}, 32'd0);
        repeat (6) begin
          @(negedge clk); #1;
          if (done) n_done++;
        end
        return;
      end
      if (gap_cyc && n_en >= 8) begin
        gap++;
        if (en) n_stall_en++;
      end
      if (en) n_en++;
      if (!en && head) n_bad++;
      if (idx >= 3 && ready) n_late++;
      if (valid && ready) idx++;
      if (done) begin
        n_done++;
        err_at_done = err;
        fin = 1;
      end
      @(negedge clk);
    end
    n_gap = gap;
    valid = 1'b0;
    if (!fin) chk("load_timeout", 32'd0, 32'd1);
    repeat (3) begin
      #1;
      if (done) n_done++;
      @(negedge clk);
    end
  endtask

  initial begin
    bit seen;
    tests = 0; fails = 0; n_vec = 0; n_gap = 0; seen = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; valid = 1'b0; data = 8'h00; flip_arm = 1'b0;
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hF7;

    // Gapless load, one row per cycle; heads follow A5, 3C, low nibble of F7, bit 0 first.
    add(1, 0, 8'h00, 5'b00000);
    add(0, 1, 8'hA5, 5'b10010);
    add(0, 1, 8'h3C, 5'b01110); add(0, 1, 8'h3C, 5'b01010); add(0, 1, 8'h3C, 5'b01110);
    add(0, 1, 8'h3C, 5'b01010); add(0, 1, 8'h3C, 5'b01010); add(0, 1, 8'h3C, 5'b01110);
    add(0, 1, 8'h3C, 5'b01010);
    add(0, 1, 8'h3C, 5'b11110);
    add(0, 1, 8'hF7, 5'b01010); add(0, 1, 8'hF7, 5'b01010); add(0, 1, 8'hF7, 5'b01110);
    add(0, 1, 8'hF7, 5'b01110); add(0, 1, 8'hF7, 5'b01110); add(0, 1, 8'hF7, 5'b01110);
    add(0, 1, 8'hF7, 5'b01010);
    add(0, 1, 8'hF7, 5'b11010);
    add(0, 0, 8'h00, 5'b01110); add(0, 0, 8'h00, 5'b01110); add(0, 0, 8'h00, 5'b01110);
    add(0, 0, 8'h00, 5'b01010);
`ifndef CCFF_VERIFY_EN
    add(0, 0, 8'h00, 5'b00001);
    add(0, 0, 8'h00, 5'b00000);
`endif

    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", {26'd0, ready, en, head, busy, done, err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < n_vec; i++) begin
      @(negedge clk);
      start = vecs[i].st; abort = vecs[i].ab; valid = vecs[i].vl; data = vecs[i].d;
      #1;
      chk($sformatf("vec%0d", i), {27'd0, ready, en, head, busy, done}, {27'd0, vecs[i].exp});
    end
    start = 1'b0; valid = 1'b0;
`ifdef CCFF_VERIFY_EN
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk); #1;
      if (done) begin
        seen = 1;
        chk("verify_clean_err", {31'd0, err}, 32'd0);
      end
    end
    if (!seen) chk("verify_done_timeout", 32'd0, 32'd1);
`endif
    @(negedge clk);
    chk("gapless_chain", {12'd0, chain}, {12'd0, EXP_CHAIN});

    // Stall of 5 cycles between words 1 and 2.
    run_load(5, 0);
    chk("stall_gap_len", n_gap, 5);
    chk("stall_en_low", n_stall_en, 0);
    chk("stall_en_count", n_en, EN_PER_LOAD);
    chk("stall_done_once", n_done, 1);
    chk("stall_chain", {12'd0, chain}, {12'd0, EXP_CHAIN});
    chk("partial_no_late_ready", n_late, 0);
    chk("head_zero_when_idle", n_bad, 0);
    chk("clean_err_at_done", {31'd0, err_at_done}, 32'd0);

    // Abort after 10 shifts, then a full load.
    run_load(0, 10);
    chk("abort_no_done", n_done, 0);
    chain = '0;
    run_load(0, 0);
    chk("reload_en_count", n_en, EN_PER_LOAD);
    chk("reload_done_once", n_done, 1);
    chk("reload_chain", {12'd0, chain}, {12'd0, EXP_CHAIN});

    // Reset held 2 cycles in the middle of a load.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; valid = 1'b1; data = 8'hA5;
    repeat (5) @(negedge clk);
    rst_n = 1'b0; valid = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      chk("midreset_outputs", {26'd0, ready, en, head, busy, done, err}, 32'd0);
    end
    rst_n = 1'b1; valid = 1'b1;
    n_done = 0; n_en = 0;
    repeat (25) begin
      @(negedge clk); #1;
      if (done || busy) n_done++;
      if (en) n_en++;
    end
    valid = 1'b0;
    chk("after_reset_quiet", n_done, 0);
    chk("after_reset_no_shift", n_en, 0);

`ifdef CCFF_VERIFY_EN
    flip_arm = 1'b1;
    run_load(0, 0);
    flip_arm = 1'b0;
    chk("flip_err_at_done", {31'd0, err_at_done}, 32'd1);
    chk("flip_done_once", n_done, 1);
    chk("flip_chain_restored", {12'd0, chain}, {12'd0, EXP_CHAIN ^ FLIP_MASK});
    chk("err_sticky", {31'd0, err}, 32'd1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    chk("start_clears_err", {30'd0, busy, err}, 32'd2);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0; #1;
    chk("abort_keeps_idle", {31'd0, busy}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
